// File: rtl/oam_dma.sv
// OAM DMA initiator: a CPU write to the DMA register copies XFER_LEN bytes from
// {src,8'h00} into OAM through the shared peripheral bus, one read/write pair per byte.
module oam_dma #(
    parameter int                DATA_SIZE    = 8,
    parameter int                ADDR_SIZE    = 16,
    parameter logic [ADDR_SIZE-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [ADDR_SIZE-1:0] OAM_BASE     = 16'hFE00,
    parameter int                XFER_LEN     = 160
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    input  logic                 cpu_we,
    output logic [DATA_SIZE-1:0] reg_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [DATA_SIZE-1:0] m_wdata,
    output logic                 m_we,
    output logic                 m_re,
    input  logic [DATA_SIZE-1:0] m_rdata
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    localparam int LAST_IDX = XFER_LEN - 1;

    state_t               state, state_nxt;
    logic [DATA_SIZE-1:0] src;
    logic [DATA_SIZE-1:0] data;
    logic [7:0]           idx;
    logic                 idx_inc;
    logic                 trigger;

    assign trigger   = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign reg_rdata = src;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src   <= '0;
            data  <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (trigger) begin
                src <= cpu_wdata;
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 8'd1;
            end
            if (state == CAPTURE)
                data <= m_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        bus_req   = 1'b0;
        done      = 1'b0;
        m_re      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        idx_inc   = 1'b0;
        case (state)
            READ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    m_re      = 1'b1;
                    // concatenation, not addition: the source never carries into the high byte
                    m_addr    = ADDR_SIZE'({src, idx});
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    m_we    = 1'b1;
                    m_addr  = OAM_BASE + ADDR_SIZE'(idx);
                    m_wdata = data;
                    if (idx == LAST_IDX[7:0]) begin
                        state_nxt = DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // a retrigger restarts from byte 0; any strobe already driven this cycle still completes
        if (trigger)
            state_nxt = READ;
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory model on the initiator bus, read/write scoreboard queues,
// directed sequence covering full copy, random grant, retrigger, reset abort and 0xFF source.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  reg_rdata;
    logic        busy, done, bus_req, bus_gnt;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_we, m_re;
    logic [7:0]  m_rdata;

    oam_dma dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .reg_rdata(reg_rdata), .busy(busy), .done(done),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  src_img [0:159];
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    int n_pass = 0, n_total = 0;
    int cyc = 0;
    int done_cnt, done_cyc, rd_cnt, wr_cnt, strobe_cnt, t_trig;
    logic [15:0] last_waddr, max_raddr;
    bit sb_en = 0, gnt_rand = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // bus target: read data valid only the cycle after m_re, junk otherwise
    always @(posedge clk) begin
        cyc = cyc + 1;
        m_rdata <= m_re ? mem[m_addr] : 8'($urandom);
        if (m_we) mem[m_addr] = m_wdata;
    end

    always @(posedge clk) begin
        #1;
        bus_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [31:0] e;
            if (m_re || m_we) begin
                check("strobe_gnt", {31'd0, bus_gnt}, 32'd1);
                check("re_we_excl", {31'd0, m_re && m_we}, 32'd0);
                strobe_cnt++;
            end
            if (m_re) begin
                rd_cnt++;
                if (m_addr > max_raddr) max_raddr = m_addr;
                if (sb_en) begin
                    e = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
                    check("rd_addr", {16'd0, m_addr}, e);
                end
            end
            if (m_we) begin
                wr_cnt++;
                last_waddr = m_addr;
                if (sb_en) begin
                    e = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
                    check("wr_addr_data", {8'd0, m_addr, m_wdata}, e);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        t_trig = cyc;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic clear_stats();
        done_cnt = 0; rd_cnt = 0; wr_cnt = 0; strobe_cnt = 0;
        max_raddr = 16'h0000; last_waddr = 16'h0000;
        rd_q.delete(); wr_q.delete();
        for (int i = 0; i < 160; i++) mem[16'hFE00 + i] = 8'h00;
    endtask

    task automatic preload(input logic [7:0] src, input int mode);
        for (int i = 0; i < 160; i++) begin
            case (mode)
                0: src_img[i] = 8'(i) ^ 8'h5A;
                1: src_img[i] = 8'($urandom);
                default: src_img[i] = 8'(i * 7 + 3);
            endcase
            mem[{src, 8'(i)}] = src_img[i];
        end
    endtask

    task automatic push_expect(input logic [7:0] src);
        for (int i = 0; i < 160; i++) begin
            rd_q.push_back({16'd0, src, 8'(i)});
            wr_q.push_back({8'd0, 16'hFE00 + 16'(i), src_img[i]});
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin tick(); n++; end
        check({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
        repeat (5) tick();
    endtask

    task automatic check_oam(input string tag);
        int bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + i] !== src_img[i]) bad++;
        check({tag, "_oam_mismatches"}, bad, 0);
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; bus_gnt = 1'b1;
        clear_stats();
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_bus_req", {31'd0, bus_req}, 0);
        check("rst_m_re", {31'd0, m_re}, 0);
        check("rst_m_we", {31'd0, m_we}, 0);
        check("rst_m_addr", {16'd0, m_addr}, 0);
        check("rst_m_wdata", {24'd0, m_wdata}, 0);
        check("rst_reg_rdata", {24'd0, reg_rdata}, 0);
        tick();
        reset = 1'b0;

        // writes to other addresses are ignored
        cpu_write(16'hFF47, 8'h12);
        cpu_write(16'hFE00, 8'h34);
        repeat (3) tick();
        check("ign_bus_req", {31'd0, bus_req}, 0);
        check("ign_busy", {31'd0, busy}, 0);
        check("ign_reg_rdata", {24'd0, reg_rdata}, 0);
        check("ign_strobes", strobe_cnt, 0);

        // full copy with grant held high
        clear_stats(); sb_en = 1;
        preload(8'hC0, 0); push_expect(8'hC0);
        cpu_write(16'hFF46, 8'hC0);
        wait_done("full");
        check("full_latency", done_cyc - t_trig, 481);
        check("full_done_cnt", done_cnt, 1);
        check("full_rd_cnt", rd_cnt, 160);
        check("full_wr_cnt", wr_cnt, 160);
        check("full_rd_q_left", rd_q.size(), 0);
        check("full_wr_q_left", wr_q.size(), 0);
        check("full_reg_rdata", {24'd0, reg_rdata}, 32'hC0);
        check("full_busy_after", {31'd0, busy}, 0);
        check_oam("full");

        // random grant
        clear_stats(); gnt_rand = 1;
        preload(8'hA3, 1); push_expect(8'hA3);
        cpu_write(16'hFF46, 8'hA3);
        wait_done("rgnt");
        gnt_rand = 0;
        check("rgnt_done_cnt", done_cnt, 1);
        check("rgnt_rd_q_left", rd_q.size(), 0);
        check("rgnt_wr_q_left", wr_q.size(), 0);
        check("rgnt_reg_rdata", {24'd0, reg_rdata}, 32'hA3);
        check_oam("rgnt");

        // retrigger mid-transfer
        clear_stats(); sb_en = 0;
        preload(8'h80, 1);
        preload(8'h90, 2);
        cpu_write(16'hFF46, 8'h80);
        repeat (100) tick();
        check("rtrg_busy_mid", {31'd0, busy}, 1);
        cpu_write(16'hFF46, 8'h90);
        wait_done("rtrg");
        check("rtrg_done_cnt", done_cnt, 1);
        check("rtrg_latency", done_cyc - t_trig, 481);
        check("rtrg_reg_rdata", {24'd0, reg_rdata}, 32'h90);
        check_oam("rtrg");

        // reset at byte 50
        clear_stats();
        cpu_write(16'hFF46, 8'hC0);
        begin
            int n = 0;
            while (wr_cnt < 50 && n < 1000) begin tick(); n++; end
        end
        check("rabt_reached_50", wr_cnt, 50);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("rabt_busy", {31'd0, busy}, 0);
        check("rabt_bus_req", {31'd0, bus_req}, 0);
        check("rabt_m_re", {31'd0, m_re}, 0);
        check("rabt_m_we", {31'd0, m_we}, 0);
        check("rabt_reg_rdata", {24'd0, reg_rdata}, 0);
        tick();
        reset = 1'b0;
        strobe_cnt = 0;
        repeat (20) tick();
        check("rabt_no_strobes", strobe_cnt, 0);
        check("rabt_done_cnt", done_cnt, 0);

        // source 0xFF: no carry past FF9F
        clear_stats(); sb_en = 1;
        preload(8'hFF, 0); push_expect(8'hFF);
        cpu_write(16'hFF46, 8'hFF);
        wait_done("ff");
        check("ff_max_raddr", {16'd0, max_raddr}, 32'hFF9F);
        check("ff_last_waddr", {16'd0, last_waddr}, 32'hFE9F);
        check("ff_rd_q_left", rd_q.size(), 0);
        check("ff_wr_q_left", wr_q.size(), 0);
        check("ff_reg_rdata", {24'd0, reg_rdata}, 32'hFF);
        check_oam("ff");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
